// File: rtl/serial_rx_buffered_pkg.sv
// Shared definitions for the buffered serial receiver.
// Holds the receive FSM state encoding, frame geometry constants and the
// even-parity check helper used by the receiver.
package serial_rx_buffered_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam int FRAME_LEN = 11;          // start + 8 data + parity + stop
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 4;
  localparam int FILL_W    = 5;           // holds 0..16 words
  localparam int WORD_W    = DATA_W + 1;  // {parity_err, data}

  // Even parity over data plus the received parity bit must be zero.
  function automatic logic parity_mismatch(input logic [DATA_W-1:0] data,
                                           input logic              par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through word buffer.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   push      - write request for wr_data (dropped when full without a pop)
//   wr_data   - word to store
//   pop       - consumer takes head word (ignored when empty)
//   rd_data   - head word, zero while empty
//   valid     - buffer non-empty
//   drop      - combinational: push rejected this cycle because full
//   fill      - number of stored words
module rx_fifo
  import serial_rx_buffered_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  rd_data,
  output logic              valid,
  output logic              drop,
  output logic [FILL_W-1:0] fill
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [FILL_W-1:0] count_q;
  logic              empty;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FILL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer still takes a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + FILL_W'(1);
        2'b01:   count_q <= count_q - FILL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the output is gated while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign valid   = !empty;
  assign fill    = count_q;

endmodule

// File: rtl/serial_rx_buffered.sv
// Serial frame receiver (one bit per clk) with a word buffer on the output.
// Frame: start(0), D0..D7 LSB first, optional even parity, stop(1).
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   Rx          - serial line, idle high
//   data_out    - head-of-buffer byte
//   parity_err  - parity flag stored with the head word
//   data_valid  - buffer non-empty
//   data_ready  - consumer accepts head word
//   frame_err   - one-cycle pulse after a low stop bit
//   overflow    - one-cycle pulse after a good frame was dropped (buffer full)
//   cnt         - bit index within the current frame, 0 when idle
//   fill        - number of buffered words
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line idle, waiting for a low start bit
// ST_DATA   | sampling D0..D7 (cnt 1..8)
// ST_PARITY | sampling parity bit, recording mismatch
// ST_STOP   | sampling stop bit; push word or flag frame error
module serial_rx_buffered
  import serial_rx_buffered_pkg::*;
#(
  parameter int PARITY_EN  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Rx,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              overflow,
  output logic [CNT_W-1:0]  cnt,
  output logic [FILL_W-1:0] fill
);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              perr_q, perr_d;
  logic              push;
  logic              ferr_d;
  logic              frame_err_q;
  logic              overflow_q;
  logic              fifo_drop;
  logic              fifo_valid;
  logic [WORD_W-1:0] fifo_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      frame_err_q <= ferr_d;
      overflow_q  <= fifo_drop;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!Rx) begin
          state_d = ST_DATA;
          cnt_d   = CNT_W'(1);
          perr_d  = 1'b0;
        end
      end
      ST_DATA: begin
        // Shifting in from the top leaves D0 in bit 0 after eight samples.
        shift_d = {Rx, shift_q[DATA_W-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W)) begin
          state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        perr_d  = parity_mismatch(shift_q, Rx);
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_STOP;
      end
      ST_STOP: begin
        push    = Rx;
        ferr_d  = !Rx;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({perr_q, shift_q}),
    .pop     (data_ready),
    .rd_data (fifo_rd_data),
    .valid   (fifo_valid),
    .drop    (fifo_drop),
    .fill    (fill)
  );

  assign data_out   = fifo_rd_data[DATA_W-1:0];
  assign parity_err = fifo_rd_data[DATA_W];
  assign data_valid = fifo_valid;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign cnt        = cnt_q;

endmodule

// File: tb/tb_serial_rx_buffered.sv
module tb_serial_rx_buffered;

  localparam int DEPTH = 4;
  localparam int LAST  = 10;   // index of the stop bit within a frame

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       parity_err;
  logic       data_valid;
  logic       frame_err;
  logic       overflow;
  logic [3:0] cnt;
  logic [4:0] fill;

  // Frame position of the bit currently on the line (-1 = idle).
  int         bit_pos = -1;
  logic [7:0] cur_byte = 8'h00;
  logic       cur_perr = 1'b0;
  bit         rand_ready = 1'b0;
  int         ready_pct = 50;

  logic [8:0] mq[$];   // model of buffered words {parity_err, byte}
  int tests = 0;
  int fails = 0;

  serial_rx_buffered #(
    .PARITY_EN  (1),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Rx         (Rx),
    .data_out   (data_out),
    .parity_err (parity_err),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .cnt        (cnt),
    .fill       (fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ready(input logic rdy);
    if (rand_ready) data_ready = (int'($urandom_range(0, 99)) < ready_pct);
    else            data_ready = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      Rx      = 1'b1;
      bit_pos = -1;
      set_ready(rdy);
    end
  endtask

  // Drives the first nbits of a frame; data_ready is rdy_last on the stop bit, else 0.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int nbits, input logic rdy_last);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (i == 0) begin
        cur_byte = b;
        cur_perr = par ^ (^b);
      end
      Rx      = bits[i];
      bit_pos = i;
      set_ready((i == LAST) ? rdy_last : 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; Rx = 1'b1; bit_pos = -1; data_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Frame-level reference: stop-bit edges push/drop/flag, ready pops the head.
  always @(posedge clk) begin : compare
    bit         pop_e, push_e, ferr_e, ovf_e;
    int         cnt_e;
    logic [8:0] head;
    if (rst) begin
      mq.delete();
      ferr_e = 1'b0;
      ovf_e  = 1'b0;
      cnt_e  = 0;
    end else begin
      push_e = (bit_pos == LAST) && Rx;
      ferr_e = (bit_pos == LAST) && !Rx;
      pop_e  = (mq.size() != 0) && data_ready;
      ovf_e  = push_e && (mq.size() == DEPTH) && !pop_e;
      if (pop_e) void'(mq.pop_front());
      if (push_e && !ovf_e) mq.push_back({cur_perr, cur_byte});
      cnt_e = (bit_pos < 0 || bit_pos == LAST) ? 0 : bit_pos + 1;
    end
    head = (mq.size() != 0) ? mq[0] : 9'h000;
    #1;
    chk("cyc_valid",     data_valid, mq.size() != 0);
    chk("cyc_fill",      fill,       mq.size());
    chk("cyc_data",      data_out,   head[7:0]);
    chk("cyc_perr",      parity_err, head[8]);
    chk("cyc_cnt",       cnt,        cnt_e);
    chk("cyc_frame_err", frame_err,  ferr_e);
    chk("cyc_overflow",  overflow,   ovf_e);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] burst [5];
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44; burst[4] = 8'h55;

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_fill",  fill, 0);
    chk("reset_cnt",   cnt, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_data",  data_out, 0);
    idle(3, 1'b0);

    // Single frame 0x43, first-word fall-through
    send_frame(8'h43, 1'b1, 1'b1, 11, 1'b0);
    idle(1, 1'b0);
    chk("one_valid", data_valid, 1);
    chk("one_data",  data_out, 8'h43);
    chk("one_perr",  parity_err, 0);
    chk("one_fill",  fill, 1);
    chk("model_pin_head", mq[0], 9'h043);
    idle(1, 1'b1);
    idle(1, 1'b0);
    chk("one_drained", fill, 0);

    // Back-to-back 0x43, 0x4C then pop both
    send_frame(8'h43, 1'b1, 1'b1, 11, 1'b0);
    send_frame(8'h4C, 1'b1, 1'b1, 11, 1'b0);
    idle(1, 1'b0);
    chk("b2b_fill2", fill, 2);
    chk("b2b_head1", data_out, 8'h43);
    idle(1, 1'b1);
    idle(1, 1'b1);
    chk("b2b_fill1", fill, 1);
    chk("b2b_head2", data_out, 8'h4C);
    idle(1, 1'b0);
    chk("b2b_fill0",  fill, 0);
    chk("b2b_valid0", data_valid, 0);

    // Parity error word is still buffered
    send_frame(8'h4C, 1'b0, 1'b1, 11, 1'b0);
    idle(1, 1'b0);
    chk("par_valid", data_valid, 1);
    chk("par_data",  data_out, 8'h4C);
    chk("par_flag",  parity_err, 1);
    chk("model_pin_perr", mq[0], 9'h14C);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Bad stop bit, then a good frame
    send_frame(8'h43, 1'b1, 1'b0, 11, 1'b0);
    idle(1, 1'b0);
    chk("ferr_pulse", frame_err, 1);
    chk("ferr_fill",  fill, 0);
    idle(1, 1'b0);
    chk("ferr_end",   frame_err, 0);
    send_frame(8'h43, 1'b1, 1'b1, 11, 1'b0);
    idle(1, 1'b0);
    chk("ferr_next_data", data_out, 8'h43);
    chk("ferr_next_fill", fill, 1);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Five frames into a four-deep buffer
    for (int i = 0; i < 5; i++) send_frame(burst[i], ^burst[i], 1'b1, 11, 1'b0);
    idle(1, 1'b0);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_fill",  fill, 4);
    chk("ovf_head",  data_out, 8'h11);
    idle(1, 1'b0);
    chk("ovf_end",   overflow, 0);

    // Push and pop together while full
    send_frame(8'h66, ^8'h66, 1'b1, 11, 1'b1);
    idle(1, 1'b0);
    chk("full_pp_fill", fill, 4);
    chk("full_pp_ovf",  overflow, 0);
    chk("full_pp_head", data_out, 8'h22);
    idle(4, 1'b1);
    idle(1, 1'b0);
    chk("full_pp_drain", fill, 0);

    // Reset in the middle of a frame with a word buffered
    send_frame(8'h77, ^8'h77, 1'b1, 11, 1'b0);
    idle(1, 1'b0);
    send_frame(8'h43, 1'b1, 1'b1, 5, 1'b0);
    @(negedge clk);
    chk("rst_mid_cnt5", cnt, 5);
    chk("rst_mid_fill", fill, 1);
    rst = 1'b1; Rx = 1'b1; bit_pos = -1; data_ready = 1'b0;
    @(negedge clk);
    chk("rst_cnt",   cnt, 0);
    chk("rst_fill",  fill, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_data",  data_out, 0);
    chk("rst_perr",  parity_err, 0);
    rst = 1'b0;
    send_frame(8'h43, 1'b1, 1'b1, 11, 1'b0);
    idle(1, 1'b0);
    chk("post_rst_data", data_out, 8'h43);
    chk("post_rst_fill", fill, 1);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Randomized traffic: random bytes, occasional bad parity/stop, gaps,
    // varying consumer rate, rare mid-frame resets.
    rand_ready = 1'b1;
    for (int f = 0; f < 200; f++) begin
      if (f % 40 == 0) begin
        case ($urandom_range(0, 2))
          0:       ready_pct = 10;
          1:       ready_pct = 50;
          default: ready_pct = 90;
        endcase
      end
      b = 8'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        send_frame(b, ^b, 1'b1, int'($urandom_range(1, 10)), 1'b0);
        do_reset();
      end else begin
        send_frame(b, (^b) ^ ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 7) != 0, 11, 1'b0);
      end
      idle(int'($urandom_range(0, 3)), 1'b0);
    end
    rand_ready = 1'b0;
    idle(8, 1'b1);
    idle(1, 1'b0);
    chk("final_drain", fill, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
